// File: rtl/inst_fetch.sv
// Instruction fetch unit: a two-state FETCH/HOLD machine that requests one word from
// instruction memory, holds it for decode, then computes the next PC from decode's decisions.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [5:0]  opCode,
  output logic [31:0] pc_out,
  input  logic        inst_ack,
  input  logic        jump,
  input  logic        branchEq,
  input  logic        branchNeq,
  input  logic        zero,
  output logic [31:0] retired_count
);

  typedef enum logic {FETCH, HOLD} state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] instReg;
  logic [31:0] pcOutReg;
  logic [31:0] retiredCnt;
  logic        latchInst;
  logic        retire;
  logic [31:0] pc4;

  function automatic logic [31:0] jumpTarget(input logic [31:0] seqPc, input logic [31:0] word);
    return {seqPc[31:28], word[25:0], 2'b00};
  endfunction

  function automatic logic [31:0] branchTarget(input logic [31:0] seqPc, input logic [31:0] word);
    logic signed [31:0] offset;
    offset = {{14{word[15]}}, word[15:0], 2'b00};
    return seqPc + $unsigned(offset);
  endfunction

  assign pc4 = pcOutReg + 32'd4;

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    latchInst = 1'b0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ready) begin
          latchInst = 1'b1;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (inst_ack) begin
          retire    = 1'b1;
          stateNext = FETCH;
          if (jump)
            pcNext = jumpTarget(pc4, instReg);
          else if ((branchEq && zero) || (branchNeq && !zero))
            pcNext = branchTarget(pc4, instReg);
          else
            pcNext = pc4;
        end
      end
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC_ALIGNED;
      instReg    <= '0;
      pcOutReg   <= '0;
      retiredCnt <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      if (latchInst) begin
        instReg  <= imem_rdata;
        pcOutReg <= pc;
      end
      if (retire)
        retiredCnt <= retiredCnt + 32'd1;
    end
  end

  // The request is masked while reset is held so memory sees no fetch until reset releases;
  // every other output comes straight from registers.
  assign imem_req      = (state == FETCH) && !reset;
  assign imem_addr     = pc;
  assign inst_valid    = (state == HOLD);
  assign inst          = instReg;
  assign opCode        = instReg[31:26];
  assign pc_out        = pcOutReg;
  assign retired_count = retiredCnt;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: vector table for the steady-state flow plus
// hand-written sequences for jump priority, stalls and reset corners.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_ack, jump, branchEq, branchNeq, zero;

  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, pc_out, retired_count;
  logic [5:0]  opCode;

  logic        reqJ, validJ;
  logic [31:0] addrJ, instJ, pcOutJ, countJ;
  logic [5:0]  opCodeJ;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .opCode(opCode), .pc_out(pc_out), .inst_ack(inst_ack),
    .jump(jump), .branchEq(branchEq), .branchNeq(branchNeq), .zero(zero),
    .retired_count(retired_count)
  );

  // Second instance with a high, misaligned reset PC for the jump-region test.
  inst_fetch #(.RESET_PC(32'h4000_0023)) dutJ (
    .clk(clk), .reset(reset), .imem_req(reqJ), .imem_addr(addrJ),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst_valid(validJ),
    .inst(instJ), .opCode(opCodeJ), .pc_out(pcOutJ), .inst_ack(inst_ack),
    .jump(jump), .branchEq(branchEq), .branchNeq(branchNeq), .zero(zero),
    .retired_count(countJ)
  );

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        ack, jmp, beq, bne, z;
    logic        expValid;
    logic [31:0] expAddr, expPcOut, expInst, expCount;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic rdy, input logic [31:0] rdata, input logic ack,
                       input logic jmp, input logic beq, input logic bne, input logic z);
    imem_ready = rdy; imem_rdata = rdata; inst_ack = ack;
    jump = jmp; branchEq = beq; branchNeq = bne; zero = z;
  endtask

  localparam logic [31:0] I0 = 32'h2001_0000, I1 = 32'h2002_0000;
  localparam logic [31:0] I2 = 32'h2003_0000, I3 = 32'h2004_0000;
  localparam logic [31:0] BQ = 32'h1000_FFFE, BN = 32'h1400_FFFE, BW = 32'h1000_FFFA;

  logic [31:0] heldInst;

  initial begin
    //           rdy rdata ack jmp beq bne z  valid addr          pcOut         inst count
    vecs[0]  = '{1, I0,    0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        I0,  32'd0};
    vecs[1]  = '{0, 32'h0, 1, 0, 0, 0, 0, 0, 32'h4,        32'h0,        I0,  32'd1};
    vecs[2]  = '{1, I1,    0, 0, 0, 0, 0, 1, 32'h4,        32'h4,        I1,  32'd1};
    vecs[3]  = '{0, 32'h0, 1, 0, 0, 0, 0, 0, 32'h8,        32'h4,        I1,  32'd2};
    vecs[4]  = '{1, I2,    0, 0, 0, 0, 0, 1, 32'h8,        32'h8,        I2,  32'd2};
    vecs[5]  = '{0, 32'h0, 1, 0, 0, 0, 0, 0, 32'hC,        32'h8,        I2,  32'd3};
    vecs[6]  = '{1, I3,    0, 0, 0, 0, 0, 1, 32'hC,        32'hC,        I3,  32'd3};
    vecs[7]  = '{0, 32'h0, 1, 0, 0, 0, 0, 0, 32'h10,       32'hC,        I3,  32'd4};
    vecs[8]  = '{1, BQ,    0, 0, 0, 0, 0, 1, 32'h10,       32'h10,       BQ,  32'd4};
    vecs[9]  = '{0, 32'h0, 1, 0, 1, 0, 1, 0, 32'hC,        32'h10,       BQ,  32'd5};
    vecs[10] = '{1, 32'h0, 0, 0, 0, 0, 0, 1, 32'hC,        32'hC,        32'h0, 32'd5};
    vecs[11] = '{0, 32'h0, 1, 0, 0, 0, 0, 0, 32'h10,       32'hC,        32'h0, 32'd6};
    vecs[12] = '{1, BQ,    0, 0, 0, 0, 0, 1, 32'h10,       32'h10,       BQ,  32'd6};
    vecs[13] = '{0, 32'h0, 1, 0, 1, 0, 0, 0, 32'h14,       32'h10,       BQ,  32'd7};
    vecs[14] = '{1, BN,    0, 1, 0, 0, 0, 1, 32'h14,       32'h14,       BN,  32'd7};
    vecs[15] = '{0, 32'h0, 1, 0, 0, 1, 0, 0, 32'h10,       32'h14,       BN,  32'd8};
    vecs[16] = '{1, BW,    0, 0, 0, 0, 0, 1, 32'h10,       32'h10,       BW,  32'd8};
    vecs[17] = '{0, 32'h0, 1, 0, 1, 0, 1, 0, 32'hFFFF_FFFC, 32'h10,       BW,  32'd9};
    vecs[18] = '{1, 32'h0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'd9};
    vecs[19] = '{0, 32'h0, 1, 0, 0, 0, 0, 0, 32'h0,        32'hFFFF_FFFC, 32'h0, 32'd10};
    vecs[20] = '{1, I0,    0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        I0,  32'd10};
    vecs[21] = '{1, I1,    0, 1, 0, 0, 0, 1, 32'h0,        32'h0,        I0,  32'd10};
    vecs[22] = '{0, 32'h0, 1, 0, 0, 1, 1, 0, 32'h4,        32'h0,        I0,  32'd11};
    vecs[23] = '{0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h4,        32'h0,        I0,  32'd11};

    reset = 1'b1;
    setIn(0, 32'h0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_addrJ", addrJ, 32'h4000_0020);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pcout", pc_out, 32'h0);
    chk("rst_count", retired_count, 32'h0);

    reset = 1'b0;
    #1;
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);

    // Jump wins over a simultaneous branchEq.
    setIn(1, 32'h0800_0040, 0, 0, 0, 0, 0);
    step();
    chk("jmp_valid", {31'h0, validJ}, 32'h1);
    chk("jmp_inst", instJ, 32'h0800_0040);
    chk("jmp_opcode", {26'h0, opCodeJ}, 32'h2);
    chk("jmp_pcout", pcOutJ, 32'h4000_0020);
    setIn(0, 32'h0, 1, 1, 1, 0, 1);
    step();
    chk("jmp_addrJ", addrJ, 32'h4000_0100);
    chk("jmp_addr", imem_addr, 32'h0000_0100);
    chk("jmp_count", retired_count, 32'h1);

    reset = 1'b1;
    setIn(0, 32'h0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      setIn(vecs[i].rdy, vecs[i].rdata, vecs[i].ack, vecs[i].jmp,
            vecs[i].beq, vecs[i].bne, vecs[i].z);
      step();
      chk($sformatf("v%0d_valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].expValid});
      chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, !vecs[i].expValid});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].expAddr);
      chk($sformatf("v%0d_pcout", i), pc_out, vecs[i].expPcOut);
      chk($sformatf("v%0d_inst", i), inst, vecs[i].expInst);
      chk($sformatf("v%0d_opcode", i), {26'h0, opCode}, {26'h0, vecs[i].expInst[31:26]});
      chk($sformatf("v%0d_count", i), retired_count, vecs[i].expCount);
    end

    // Memory stalls three cycles, then decode stalls two.
    for (int i = 0; i < 3; i++) begin
      setIn(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
      step();
      chk($sformatf("stall%0d_addr", i), imem_addr, 32'h4);
      chk($sformatf("stall%0d_req", i), {31'h0, imem_req}, 32'h1);
    end
    chk("stall_accept_addr", imem_addr, 32'h4);
    setIn(1, 32'hAC00_1234, 0, 0, 0, 0, 0);
    step();
    heldInst = 32'hAC00_1234;
    for (int i = 0; i < 2; i++) begin
      setIn(1, 32'h5555_5555, 0, 1, 1, 1, 0);
      step();
      chk($sformatf("hold%0d_inst", i), inst, heldInst);
      chk($sformatf("hold%0d_opcode", i), {26'h0, opCode}, 32'h2B);
      chk($sformatf("hold%0d_valid", i), {31'h0, inst_valid}, 32'h1);
      chk($sformatf("hold%0d_count", i), retired_count, 32'd11);
    end
    setIn(0, 32'h0, 1, 0, 0, 0, 0);
    step();
    chk("stall_done_addr", imem_addr, 32'h8);
    chk("stall_done_count", retired_count, 32'd12);

    // Reset mid-FETCH with a response pending clears the count and discards the word.
    setIn(1, 32'h1111_1111, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("rstf_count", retired_count, 32'h0);
    chk("rstf_req", {31'h0, imem_req}, 32'h0);
    step();
    chk("rstf_inst", inst, 32'h0);
    chk("rstf_valid", {31'h0, inst_valid}, 32'h0);
    reset = 1'b0;

    // Reset arriving on the same edge as an acknowledge in HOLD.
    setIn(1, 32'h2222_2222, 0, 0, 0, 0, 0);
    step();
    chk("rsth_valid_before", {31'h0, inst_valid}, 32'h1);
    setIn(0, 32'h0, 1, 1, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("rsth_valid", {31'h0, inst_valid}, 32'h0);
    chk("rsth_req", {31'h0, imem_req}, 32'h0);
    chk("rsth_addr", imem_addr, 32'h0);
    step();
    chk("rsth_count", retired_count, 32'h0);
    chk("rsth_pcout", pc_out, 32'h0);
    reset = 1'b0;
    setIn(0, 32'h0, 0, 0, 0, 0, 0);
    #1;
    chk("rsth_req_after", {31'h0, imem_req}, 32'h1);
    chk("rsth_addr_after", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] forced to 2'b00.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears state immediately.
REQ-004 Port: imem_req  output  1  instruction-memory read request, held until imem_ready.
REQ-005 Port: imem_addr  output  32  word-aligned fetch address (current PC).
REQ-006 Port: imem_ready  input  1  memory response valid for current request.
REQ-007 Port: imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-008 Port: inst_valid  output  1  held instruction available to decode.
REQ-009 Port: inst  output  32  held instruction word.
REQ-010 Port: opCode  output  6  inst[31:26], feeds control-unit opcode input.
REQ-011 Port: pc_out  output  32  address of held instruction.
REQ-012 Port: inst_ack  input  1  decode consumes held instruction this cycle.
REQ-013 Port: jump, branchEq, branchNeq  input  1 each  control-unit decisions for held instruction.
REQ-014 Port: zero  input  1  ALU zero flag for held instruction.
REQ-015 Port: retired_count  output  32  number of acknowledged instructions.

Function
REQ-016 Two states: FETCH (imem_req=1, inst_valid=0) and HOLD (imem_req=0, inst_valid=1).
REQ-017 FETCH: imem_addr=PC; on edge with imem_ready=1 latch imem_rdata into inst, pc_out<=PC, go HOLD; else stay FETCH, address stable.
REQ-018 HOLD: inst, pc_out, opCode stable; on edge with inst_ack=1 update PC per REQ-019..022, retired_count+1, go FETCH.
REQ-019 Next PC priority: jump -> {pc4[31:28], inst[25:0], 2'b00}; else branchEq&zero -> branch target; else branchNeq&!zero -> branch target; else pc4.
REQ-020 pc4 = pc_out + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-021 Branch target = pc4 + (sign-extended inst[15:0] << 2), modulo 2^32.
REQ-022 jump, branchEq, branchNeq, zero sampled only on the inst_ack edge in HOLD; ignored otherwise.
REQ-023 imem_ready outside FETCH ignored; inst_ack outside HOLD ignored.
REQ-024 Minimum throughput: one instruction per 2 cycles (imem_ready=1 in first FETCH cycle, inst_ack=1 in first HOLD cycle).
REQ-025 retired_count wraps 0xFFFF_FFFF -> 0.
REQ-026 All outputs registered or decoded from state/registers only; no combinational path from inputs to outputs.

Reset
REQ-027 reset=1: state<=FETCH, PC<=RESET_PC, inst<=0, pc_out<=0, retired_count<=0, inst_valid=0, imem_req=0 while reset held.
REQ-028 Reset mid-FETCH or mid-HOLD aborts; pending response discarded, held instruction dropped, count not incremented.
REQ-029 After reset deasserts, imem_req=1 with imem_addr=RESET_PC on first cycle.

Verification
REQ-030 Sequential: RESET_PC=0, memory returns 1 cycle, ack immediate, no control -> imem_addr 0,4,8,12; retired_count 4 after 8 cycles.
REQ-031 Branch taken: inst at 0x10 = 0x1000_FFFE, branchEq=1, zero=1 on ack -> next imem_addr 0x0C; zero=0 -> 0x14.
REQ-032 Jump: pc_out 0x4000_0020, inst 0x0800_0040, jump=1, branchEq=1 -> next imem_addr 0x4000_0100 (jump wins).
REQ-033 Stalls: imem_ready low 3 cycles then high; inst_ack low 2 cycles -> imem_addr stable 4 cycles, inst/opCode stable through HOLD, one increment.
REQ-034 Wrap: pc_out 0xFFFF_FFFC, no control -> next imem_addr 0x0000_0000.
REQ-035 Reset in HOLD with inst_ack=1 same edge -> PC=RESET_PC, retired_count unchanged at 0, inst_valid=0 immediately.
